// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine driving a shared ALU, one iteration per cycle
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] acc, q, m, rem_sh, abs_a, abs_b, rem_fix, quo_fix;
  logic [2*W-1:0] prod_fix;
  logic [CW-1:0] cnt;
  logic is_div, sgn, a_sign, b_sign, dbz, sub_ok, carry;
  always_comb begin
    rem_sh = {acc[W-2:0], q[W-1]};
    sub_ok = acc[W-1] | (rem_sh >= m);
    carry = alu_result < acc;
    abs_a = (sgn & q[W-1]) ? -q : q;
    abs_b = (sgn & m[W-1]) ? -m : m;
    prod_fix = (a_sign ^ b_sign) ? -{acc, q} : {acc, q};
    rem_fix = a_sign ? -acc : acc;
    quo_fix = dbz ? '1 : (a_sign ^ b_sign) ? -q : q;
    busy = state == PREP || state == ITER || state == FIX;
    done = state == DONE;
    alu_op = (state == ITER && is_div) ? ALU_SUB : ALU_ADD;
    alu_a = state != ITER ? '0 : is_div ? rem_sh : acc;
    alu_b = state == ITER ? m : '0;
    state_nx = flush ? IDLE :
               state == IDLE ? (start ? PREP : IDLE) :
               state == PREP ? ITER :
               state == ITER ? (cnt == CW'(1) ? FIX : ITER) :
               state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      q <= '0;
      m <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      sgn <= 1'b0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      dbz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == PREP) begin
        q <= src_a;
        m <= src_b;
        is_div <= op[1];
        sgn <= ~op[0];
      end
      // operands are reordered so multiply keeps the multiplier in q and divide keeps the dividend in q
      if (state == PREP) begin
        a_sign <= sgn & q[W-1];
        b_sign <= sgn & m[W-1];
        dbz <= is_div & (m == '0);
        acc <= '0;
        cnt <= CW'(W);
        q <= is_div ? abs_a : abs_b;
        m <= is_div ? abs_b : abs_a;
      end
      if (state == ITER) begin
        cnt <= cnt - CW'(1);
        if (is_div) begin
          acc <= sub_ok ? alu_result : rem_sh;
          q <= {q[W-2:0], sub_ok};
        end else begin
          acc <= q[0] ? {carry, alu_result[W-1:1]} : {1'b0, acc[W-1:1]};
          q <= {q[0] ? alu_result[0] : acc[0], q[W-1:1]};
        end
      end
      // divide by zero leaves |a| in acc, so the remainder sign fix restores the raw dividend
      if (state == FIX && !flush) begin
        hi <= is_div ? rem_fix : prod_fix[2*W-1:W];
        lo <= is_div ? quo_fix : prod_fix[W-1:0];
      end
    end
  end
endmodule
